fb_writer: RTL

//   Write-side engine for the VGA framebuffer BRAM (simple dual-port, write port on clk).

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_writer_if.sv | 18 +
 rtl/fb_addr_calc.sv | 14 +
 rtl/fb_writer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer types and default geometry shared by the writer and reader sides.
package fb_pkg;
  localparam int DRAW_WIDTH_DFLT  = 640;
  localparam int DRAW_HEIGHT_DFLT = 480;
  localparam int DRAW_SIZE_DFLT   = DRAW_WIDTH_DFLT * DRAW_HEIGHT_DFLT;
  localparam int DRAW_ADDRW_DFLT  = $clog2(DRAW_SIZE_DFLT);
  localparam int DRAW_DATAW       = 1;
  typedef enum logic [1:0] {IDLE, CLEAR, BLOB} fb_state_t;
  typedef struct packed {
    logic [9:0]            x;
    logic [9:0]            y;
    logic [DRAW_DATAW-1:0] color;
  } point_t;
endpackage

// File: rtl/fb_writer_if.sv
// fb_writer_if: point stream in, framebuffer write port out.
interface fb_writer_if #(
  parameter int ADDRW = fb_pkg::DRAW_ADDRW_DFLT,
  parameter int DATAW = fb_pkg::DRAW_DATAW
);
  logic             pt_valid;
  logic             pt_ready;
  logic [9:0]       pt_x;
  logic [9:0]       pt_y;
  logic [DATAW-1:0] pt_color;
  logic [ADDRW-1:0] draw_addr_write;
  logic [DATAW-1:0] draw_data_in;
  logic             draw_we;
  modport master(input pt_valid, pt_x, pt_y, pt_color,
                 output pt_ready, draw_addr_write, draw_data_in, draw_we);
  modport slave(output pt_valid, pt_x, pt_y, pt_color,
                input pt_ready, draw_addr_write, draw_data_in, draw_we);
endinterface

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: (x,y) to linear framebuffer address plus on-screen flag.
module fb_addr_calc #(
  parameter int W  = fb_pkg::DRAW_WIDTH_DFLT,
  parameter int H  = fb_pkg::DRAW_HEIGHT_DFLT,
  parameter int AW = fb_pkg::DRAW_ADDRW_DFLT
)(
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [AW-1:0] addr,
  output logic          in_range
);
  assign in_range = int'(x) < W && int'(y) < H;
  assign addr     = AW'(int'(y) * W + int'(x));
endmodule

// File: rtl/fb_writer.sv
// fb_writer: plots points and clear sweeps into the framebuffer write port.
// Define FB_WRITER_BLOB_EN to draw each point as a 2x2 blob.
module fb_writer import fb_pkg::*; #(
  parameter int DRAW_WIDTH  = DRAW_WIDTH_DFLT,
  parameter int DRAW_HEIGHT = DRAW_HEIGHT_DFLT,
  parameter int DRAW_ADDRW  = $clog2(DRAW_WIDTH * DRAW_HEIGHT),
  parameter logic [DRAW_DATAW-1:0] BG_COLOR = '0
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_req,
  fb_writer_if.master        f,
  output logic               busy,
  output logic               clear_done,
  output logic [15:0]        drop_count
);
  localparam int DRAW_SIZE = DRAW_WIDTH * DRAW_HEIGHT;
  fb_state_t state_q, state_d;
  logic we_q, we_d, done_q, done_d, cin;
  logic [DRAW_ADDRW-1:0] addr_q, addr_d, caddr;
  logic [DRAW_DATAW-1:0] data_q, data_d;
  logic [15:0] drop_q, drop_d;
  logic [9:0] cx, cy;
`ifdef FB_WRITER_BLOB_EN
  logic [1:0] slot_q, slot_d;
  point_t pt_q, pt_d;
  assign cx = (state_q == BLOB) ? pt_q.x + 10'(slot_q[0]) : f.pt_x;
  assign cy = (state_q == BLOB) ? pt_q.y + 10'(slot_q[1]) : f.pt_y;
`else
  assign cx = f.pt_x;
  assign cy = f.pt_y;
`endif
  fb_addr_calc #(.W(DRAW_WIDTH), .H(DRAW_HEIGHT), .AW(DRAW_ADDRW)) u_calc (
    .x(cx), .y(cy), .addr(caddr), .in_range(cin)
  );
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
`ifdef FB_WRITER_BLOB_EN
    slot_d  = slot_q;
    pt_d    = pt_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear_req) state_d = CLEAR;
        else if (f.pt_valid) begin
          if (cin) begin
            we_d   = 1'b1;
            addr_d = caddr;
            data_d = f.pt_color;
`ifdef FB_WRITER_BLOB_EN
            state_d = BLOB;
            slot_d  = 2'd1;
            pt_d    = '{x: f.pt_x, y: f.pt_y, color: f.pt_color};
`endif
          end else drop_d = drop_q + {15'd0, ~&drop_q};
        end
      end
      CLEAR: begin
        // The sweep counts through addr_q itself; we_q low marks the first slot.
        if (we_q && addr_q == DRAW_ADDRW'(DRAW_SIZE - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = we_q ? addr_q + 1'b1 : '0;
          data_d = BG_COLOR;
        end
      end
`ifdef FB_WRITER_BLOB_EN
      BLOB: begin
        if (slot_q == 2'd0) state_d = IDLE;
        else begin
          we_d   = cin;
          addr_d = cin ? caddr : addr_q;
          data_d = cin ? pt_q.color : data_q;
          slot_d = slot_q + 2'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
`ifdef FB_WRITER_BLOB_EN
      slot_q  <= '0;
      pt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
`ifdef FB_WRITER_BLOB_EN
      slot_q  <= slot_d;
      pt_q    <= pt_d;
`endif
    end
  end
  assign f.pt_ready        = state_q == IDLE && !clear_req;
  assign f.draw_we         = we_q;
  assign f.draw_addr_write = addr_q;
  assign f.draw_data_in    = data_q;
  assign busy              = state_q != IDLE;
  assign clear_done        = done_q;
  assign drop_count        = drop_q;
endmodule
